// File: rtl/mult_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mult_sequencer_pkg
//
// Shared definitions for the multiply sequencer: the FSM state encoding,
// the default LEGv8 MUL opcode, the watchdog counter width and a small
// helper that classifies the retire states.
// -----------------------------------------------------------------------------
package mult_sequencer_pkg;

    // Default datapath width and MUL opcode of the execute stage.
    localparam int          WORD_DEFAULT       = 64;
    localparam logic [10:0] MUL_OPCODE_DEFAULT = 11'b10011011000;

    // Width of the BUSY-cycle counter and of the busy_cycles report.
    localparam int          CNT_W              = 8;

    // 3-bit state encoding shared by the RTL and anything that decodes
    // the debug state output.
    typedef enum logic [2:0] {
        MS_IDLE  = 3'd0,
        MS_START = 3'd1,
        MS_BUSY  = 3'd2,
        MS_DONE  = 3'd3,
        MS_ERR   = 3'd4
    } ms_state_t;

    // DONE and ERR both retire a result (the product or zero) for one cycle.
    function automatic logic is_retire(input ms_state_t s);
        return (s == MS_DONE) || (s == MS_ERR);
    endfunction

endpackage : mult_sequencer_pkg

// File: rtl/mult_sequencer_if.sv
// -----------------------------------------------------------------------------
// mult_sequencer_if
//
// Connection between the sequencer (master) and the iterative multiplier
// (slave).
//
// Handshake:
//   mult_start  - master -> slave, a single-cycle pulse that launches one
//                 multiply. It is never held high for more than one cycle.
//   mult_done   - slave -> master, a single-cycle completion pulse.
//   mult_result - slave -> master, the product; it only has meaning in the
//                 cycle where mult_done is 1.
//   There is no back-pressure: the sequencer accepts mult_done whenever it
//   is waiting for it and ignores it at any other time.
//
// Ports (modports):
//   master : output mult_start; input mult_done, mult_result
//   slave  : input mult_start; output mult_done, mult_result
// -----------------------------------------------------------------------------
interface mult_sequencer_if #(
    parameter int WORD = 64
) ();

    logic            mult_start;
    logic            mult_done;
    logic [WORD-1:0] mult_result;

    modport master (
        output mult_start,
        input  mult_done,
        input  mult_result
    );

    modport slave (
        input  mult_start,
        output mult_done,
        output mult_result
    );

endinterface : mult_sequencer_if

// File: rtl/mult_sequencer_watchdog_counter.sv
// -----------------------------------------------------------------------------
// watchdog_counter
//
// 8-bit cycle counter used as the multiply latency watchdog. clear has
// priority over enable. terminal is high while the count equals TIMEOUT-1,
// i.e. during the last BUSY cycle that is allowed before the error path.
//
// Ports:
//   clk      in  1      rising-edge clock
//   reset    in  1      asynchronous, active-low reset
//   clear    in  1      synchronous clear to 0
//   enable   in  1      increment by one
//   count    out CNT_W  current count
//   terminal out 1      count == TIMEOUT-1
// -----------------------------------------------------------------------------
module watchdog_counter
    import mult_sequencer_pkg::*;
#(
    // Valid range is 2..255 so that TIMEOUT-1 fits the 8-bit counter and
    // at least one BUSY cycle exists before the terminal count.
    parameter int TIMEOUT = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] TERM_COUNT = CNT_W'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == TERM_COUNT);

endmodule : watchdog_counter

// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
//
// Control FSM that owns the execute stage's iterative multiplier. When a
// valid MUL reaches execute it stalls the front of the pipeline, pulses
// mult_start, waits for mult_done (bounded by a watchdog), then steers the
// execute result mux to the captured product for exactly one retire cycle.
// Status-register updates are masked for the whole MUL, including retire.
//
// Ports:
//   clk                in  1      rising-edge clock
//   reset              in  1      asynchronous, active-low reset
//   instr_valid        in  1      opcode belongs to a real instruction
//   opcode             in  11     opcode of the instruction in execute
//   mif                master     mult_start / mult_done / mult_result
//   stall              out 1      freezes PC and IF/ID
//   execute_result_loc out 1      1 selects the multiplier result
//   sreg_block         out 1      gates update_sreg low
//   result             out WORD   captured product (0 after a timeout)
//   result_valid       out 1      result retires this cycle
//   timeout_err        out 1      sticky watchdog flag, cleared only by reset
//   busy_cycles        out 8      BUSY-cycle count of the last completed MUL
//   state_dbg          out 3      current FSM state
//
// Cycle map for one MUL whose done arrives in cycle k:
//   0 IDLE (mul_hit, stall already high), 1 START, 2..k BUSY, k+1 DONE.
// -----------------------------------------------------------------------------
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int          WORD       = WORD_DEFAULT,
    parameter logic [10:0] MUL_OPCODE = MUL_OPCODE_DEFAULT,
    parameter int          TIMEOUT    = 80
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [10:0]        opcode,
    mult_sequencer_if.master   mif,
    output logic               stall,
    output logic               execute_result_loc,
    output logic               sreg_block,
    output logic [WORD-1:0]    result,
    output logic               result_valid,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   busy_cycles,
    output ms_state_t          state_dbg
);

    ms_state_t        state;
    logic             mul_hit;
    logic             cnt_clear;
    logic             cnt_enable;
    logic [CNT_W-1:0] cnt;
    logic             cnt_terminal;
    logic             retiring;

    assign mul_hit = instr_valid && (opcode == MUL_OPCODE);

    // The counter is zeroed in START so that its value in BUSY equals the
    // number of BUSY cycles already completed before the current one.
    assign cnt_clear  = (state == MS_START);
    assign cnt_enable = (state == MS_BUSY);

    watchdog_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (cnt),
        .terminal (cnt_terminal)
    );

    // State plus the registered outputs (result, busy_cycles, timeout_err).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= MS_IDLE;
            result      <= '0;
            busy_cycles <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                MS_IDLE: begin
                    if (mul_hit) begin
                        state <= MS_START;
                    end
                end

                // mult_done is deliberately not looked at here: the
                // multiplier has not been started yet.
                MS_START: begin
                    state <= MS_BUSY;
                end

                // Completion takes priority over the watchdog, so a done in
                // the terminal cycle still retires the real product.
                MS_BUSY: begin
                    if (mif.mult_done) begin
                        result      <= mif.mult_result;
                        busy_cycles <= cnt + CNT_W'(1);
                        state       <= MS_DONE;
                    end else if (cnt_terminal) begin
                        timeout_err <= 1'b1;
                        result      <= '0;
                        state       <= MS_ERR;
                    end
                end

                // Retire cycles always return to IDLE; whatever opcode is
                // present now is the instruction that was stalled behind the
                // MUL and is only examined next cycle.
                MS_DONE, MS_ERR: begin
                    state <= MS_IDLE;
                end

                default: begin
                    state <= MS_IDLE;
                end
            endcase
        end
    end

    assign retiring = is_retire(state);

    // Decoded outputs. The IDLE term on stall is combinational so that the
    // decode cycle holding the MUL is frozen in the same cycle it is seen.
    // It is qualified with reset so that every output reads 0 while reset
    // is asserted, even if a MUL happens to be presented at that moment.
    assign mif.mult_start     = (state == MS_START);
    assign stall              = (state == MS_START) || (state == MS_BUSY) ||
                                ((state == MS_IDLE) && mul_hit && reset);
    assign sreg_block         = stall || retiring;
    assign execute_result_loc = retiring;
    assign result_valid       = retiring;
    assign state_dbg          = state;

endmodule : mult_sequencer

// File: tb/tb_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_sequencer
//
// Directed scenarios followed by randomized MUL traffic. Each issued MUL
// pushes its expected retire (result, busy_cycles, timeout_err, cycle) onto
// exp_q; a monitor pops and compares whenever result_valid is seen. A small
// behavioural multiplier answers mult_start after a per-MUL delay.
// -----------------------------------------------------------------------------
module tb_mult_sequencer;
    import mult_sequencer_pkg::*;

    localparam int          W       = 64;
    localparam int          T       = 5;
    localparam logic [10:0] MUL_OP  = 11'b10011011000;
    localparam logic [10:0] ADD_OP  = 11'b10001011000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT ----------------
    logic            instr_valid;
    logic [10:0]     opcode;
    logic            stall;
    logic            execute_result_loc;
    logic            sreg_block;
    logic [W-1:0]    result;
    logic            result_valid;
    logic            timeout_err;
    logic [7:0]      busy_cycles;
    ms_state_t       state_dbg;

    logic            model_done = 1'b0;
    logic [W-1:0]    model_res  = '0;
    logic            spur_done  = 1'b0;
    logic [W-1:0]    spur_res   = '0;

    mult_sequencer_if #(.WORD(W)) mif ();
    assign mif.mult_done   = model_done | spur_done;
    assign mif.mult_result = model_done ? model_res : spur_res;

    mult_sequencer #(
        .WORD       (W),
        .MUL_OPCODE (MUL_OP),
        .TIMEOUT    (T)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .instr_valid        (instr_valid),
        .opcode             (opcode),
        .mif                (mif),
        .stall              (stall),
        .execute_result_loc (execute_result_loc),
        .sreg_block         (sreg_block),
        .result             (result),
        .result_valid       (result_valid),
        .timeout_err        (timeout_err),
        .busy_cycles        (busy_cycles),
        .state_dbg          (state_dbg)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [W-1:0] res;
        logic [7:0]   busy;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           delay_q[$];
    logic [W-1:0] prod_q[$];
    int           total = 0;
    int           bad   = 0;

    // Reference state: sticky error flag and last completed BUSY count.
    logic         ref_err  = 1'b0;
    logic [7:0]   ref_busy = 8'd0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A done that arrives within TIMEOUT BUSY cycles retires the product with
    // busy_cycles = delay. Otherwise (delay 0 = never, or too late) the
    // watchdog fires after TIMEOUT BUSY cycles and zero retires.
    task automatic issue_mul(input int d, input logic [W-1:0] p);
        exp_t e;
        if (d >= 1 && d <= T) begin
            ref_busy = 8'(d);
            e.res    = p;
            e.cyc    = cyc + d + 2;
        end else begin
            ref_err  = 1'b1;
            e.res    = '0;
            e.cyc    = cyc + T + 2;
        end
        e.busy = ref_busy;
        e.err  = ref_err;
        exp_q.push_back(e);
        delay_q.push_back(d);
        prod_q.push_back(p);
        instr_valid = 1'b1;
        opcode      = MUL_OP;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (reset && result_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_retire: got result_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_result",      result,             mon_e.res);
                chk("sb_busy_cycles", W'(busy_cycles),    W'(mon_e.busy));
                chk("sb_timeout_err", W'(timeout_err),    W'(mon_e.err));
                chk("sb_retire_cyc",  W'(cyc),            W'(mon_e.cyc));
                chk("sb_result_loc",  W'(execute_result_loc), W'(1));
                chk("sb_stall_low",   W'(stall),          W'(0));
                chk("sb_sreg_block",  W'(sreg_block),     W'(1));
            end
        end
    end

    // ---------------- behavioural multiplier ----------------
    initial begin
        int           d;
        logic [W-1:0] p;
        forever begin
            @(negedge clk);
            if (mif.mult_start) begin
                d = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                p = (prod_q.size()  > 0) ? prod_q.pop_front()  : '0;
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1;
                    model_done = 1'b1;
                    model_res  = p;
                    @(posedge clk);
                    #1;
                    model_done = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        instr_valid = 1'($urandom_range(0, 1));
        opcode      = 11'($urandom);
        if (instr_valid && opcode == MUL_OP) opcode = opcode ^ 11'd1;
    endtask

    // Traffic while the MUL is in flight; MULs here must be ignored.
    task automatic busy_noise();
        instr_valid = 1'($urandom_range(0, 1));
        opcode      = ($urandom_range(0, 1) != 0) ? MUL_OP : 11'($urandom);
    endtask

    task automatic wait_retire();
        logic got = 1'b0;
        for (int i = 0; i < T + 12; i++) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("retire_seen", W'(got), W'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] p;
        int           starts;
        logic         rv_seen;

        reset       = 1'b0;
        instr_valid = 1'b0;
        opcode      = '0;
        step();
        chk("rst_state",  W'(state_dbg),   W'(MS_IDLE));
        chk("rst_result", result,          '0);
        chk("rst_stall",  W'(stall),       W'(0));
        chk("rst_err",    W'(timeout_err), W'(0));
        chk("rst_busy",   W'(busy_cycles), W'(0));
        reset = 1'b1;
        step();

        // Single MUL: done four cycles after mult_start.
        for (int c = 0; c < 8; c++) begin
            if (c == 0) issue_mul(4, W'(42));
            else        instr_valid = 1'b0;
            @(negedge clk);
            chk("single_stall",  W'(stall),          W'(c <= 5));
            chk("single_start",  W'(mif.mult_start), W'(c == 1));
            chk("single_rv",     W'(result_valid),   W'(c == 6));
            if (c == 6) begin
                chk("single_result", result,           W'(42));
                chk("single_busy",   W'(busy_cycles),  W'(4));
                chk("single_loc",    W'(execute_result_loc), W'(1));
            end
            step();
        end

        // Non-MUL traffic.
        instr_valid = 1'b1;
        opcode      = ADD_OP;
        @(negedge clk);
        chk("add_stall", W'(stall),      W'(0));
        chk("add_sreg",  W'(sreg_block), W'(0));
        step();
        @(negedge clk);
        chk("add_no_start", W'(mif.mult_start), W'(0));
        instr_valid = 1'b0;
        opcode      = MUL_OP;
        step();
        @(negedge clk);
        chk("bubble_stall", W'(stall), W'(0));
        step();
        @(negedge clk);
        chk("bubble_no_start", W'(mif.mult_start), W'(0));
        chk("bubble_idle",     W'(state_dbg),      W'(MS_IDLE));
        step();

        // Done coincident with the terminal BUSY cycle.
        p = {$urandom, $urandom};
        for (int c = 0; c < 9; c++) begin
            if (c == 0) issue_mul(T, p);
            else        instr_valid = 1'b0;
            @(negedge clk);
            if (c == 6) chk("coinc_busy_state", W'(state_dbg), W'(MS_BUSY));
            if (c == 7) begin
                chk("coinc_done_state", W'(state_dbg),   W'(MS_DONE));
                chk("coinc_no_err",     W'(timeout_err), W'(0));
                chk("coinc_result",     result,          p);
            end
            step();
        end

        // Timeout: done never arrives.
        for (int c = 0; c < 9; c++) begin
            if (c == 0) issue_mul(0, '0);
            else        instr_valid = 1'b0;
            @(negedge clk);
            if (c == 6) chk("to_err_before", W'(timeout_err), W'(0));
            if (c == 7) begin
                chk("to_err_state", W'(state_dbg),   W'(MS_ERR));
                chk("to_result",    result,          '0);
                chk("to_err_flag",  W'(timeout_err), W'(1));
            end
            step();
        end

        // Follow-up MUL after a timeout completes normally.
        issue_mul(2, {$urandom, $urandom});
        step();
        instr_valid = 1'b0;
        wait_retire();
        chk("follow_busy", W'(busy_cycles), W'(2));
        chk("follow_err",  W'(timeout_err), W'(1));
        step();

        // Reset asserted in the middle of BUSY.
        for (int c = 0; c < 3; c++) begin
            if (c == 0) issue_mul(3, {$urandom, $urandom});
            else        instr_valid = 1'b0;
            step();
        end
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_state", W'(state_dbg),          W'(MS_IDLE));
        chk("mid_rst_stall", W'(stall),              W'(0));
        chk("mid_rst_sreg",  W'(sreg_block),         W'(0));
        chk("mid_rst_start", W'(mif.mult_start),     W'(0));
        chk("mid_rst_rv",    W'(result_valid),       W'(0));
        chk("mid_rst_loc",   W'(execute_result_loc), W'(0));
        chk("mid_rst_res",   result,                 '0);
        chk("mid_rst_err",   W'(timeout_err),        W'(0));
        chk("mid_rst_busy",  W'(busy_cycles),        W'(0));
        exp_q.delete();
        ref_err  = 1'b0;
        ref_busy = 8'd0;
        @(negedge clk);
        #2;
        reset   = 1'b1;
        rv_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (result_valid) rv_seen = 1'b1;
        end
        chk("mid_rst_no_retire", W'(rv_seen), W'(0));
        step();

        // Back-to-back MULs with spurious done in IDLE, DONE and START.
        spur_done = 1'b1;
        spur_res  = {$urandom, $urandom};
        step();
        starts = 0;
        p      = {$urandom, $urandom};
        for (int c = 0; c < 12; c++) begin
            spur_done = (c == 3) || (c == 5);
            spur_res  = {$urandom, $urandom};
            if (c == 0)      issue_mul(1, p);
            else if (c == 4) issue_mul(2, {$urandom, $urandom});
            else             instr_valid = 1'b0;
            @(negedge clk);
            if (mif.mult_start) starts++;
            chk("b2b_start", W'(mif.mult_start), W'(c == 1 || c == 5));
            if (c == 4) begin
                chk("b2b_gap_idle",   W'(state_dbg), W'(MS_IDLE));
                chk("b2b_result_kept", result,       p);
            end
            step();
        end
        spur_done = 1'b0;
        chk("b2b_starts", W'(starts), W'(2));

        // Randomized traffic.
        for (int n = 0; n < 25; n++) begin
            int g;
            int d;
            g = $urandom_range(0, 3);
            repeat (g) begin
                noise();
                step();
            end
            d = $urandom_range(0, T + 2);
            issue_mul(d, {$urandom, $urandom});
            step();
            busy_noise();
            wait_retire();
            step();
            noise();
        end
        instr_valid = 1'b0;
        repeat (T + 6) step();

        chk("sb_empty", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mult_sequencer
